// File: rtl/extio8x4_axis_rxfifo2_if.sv
// Handshake bundle for the dual-channel rx byte FIFO: two producer-side
// streams, two target-side streams and the per-channel fill levels.
interface extio8x4_axis_rxfifo2_if #(
  parameter int LW = 3
);
  logic          s0_tvalid;
  logic          s0_tready;
  logic [7:0]    s0_tdata8;
  logic          s1_tvalid;
  logic          s1_tready;
  logic [7:0]    s1_tdata8;
  logic          m0_tvalid;
  logic          m0_tready;
  logic [7:0]    m0_tdata8;
  logic          m1_tvalid;
  logic          m1_tready;
  logic [7:0]    m1_tdata8;
  logic [LW-1:0] level0;
  logic [LW-1:0] level1;

  // FIFO side
  modport slave (
    input  s0_tvalid, s0_tdata8, s1_tvalid, s1_tdata8, m0_tready, m1_tready,
    output s0_tready, s1_tready, m0_tvalid, m0_tdata8, m1_tvalid, m1_tdata8,
           level0, level1
  );

  // Producer/target side
  modport master (
    output s0_tvalid, s0_tdata8, s1_tvalid, s1_tdata8, m0_tready, m1_tready,
    input  s0_tready, s1_tready, m0_tvalid, m0_tdata8, m1_tvalid, m1_tdata8,
           level0, level1
  );
endinterface

// File: rtl/extio8x4_axis_rxfifo2.sv
// Dual-channel byte FIFO feeding the target's axis_rx0/axis_rx1 ports.
// Registered storage with combinational head read; no fall-through path.
module extio8x4_axis_rxfifo2 #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  extio8x4_axis_rxfifo2_if.slave        bus
);
  localparam int PW = $clog2(DEPTH);

  logic [1:0]          in_valid;
  logic [1:0]          in_ready;
  logic [1:0]          out_valid;
  logic [1:0]          out_ready;
  logic [1:0][7:0]     in_data;
  logic [1:0][7:0]     out_data;
  logic [1:0][LW-1:0]  level;

  assign in_valid  = {bus.s1_tvalid, bus.s0_tvalid};
  assign in_data   = {bus.s1_tdata8, bus.s0_tdata8};
  assign out_ready = {bus.m1_tready, bus.m0_tready};

  assign bus.s0_tready = in_ready[0];
  assign bus.s1_tready = in_ready[1];
  assign bus.m0_tvalid = out_valid[0];
  assign bus.m1_tvalid = out_valid[1];
  assign bus.m0_tdata8 = out_data[0];
  assign bus.m1_tdata8 = out_data[1];
  assign bus.level0    = level[0];
  assign bus.level1    = level[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] count;
    logic          push;
    logic          pop;

    // Flush masks both handshakes, so it wins over any transfer that cycle.
    assign in_ready[c]  = (count != LW'(DEPTH)) && !flush;
    assign out_valid[c] = (count != '0) && !flush;
    assign push         = in_valid[c] && in_ready[c];
    assign pop          = out_valid[c] && out_ready[c];
    assign out_data[c]  = mem[rptr];
    assign level[c]     = count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + LW'(1);
          2'b01:   count <= count - LW'(1);
          default: count <= count;
        endcase
      end
    end

    // NOTE: storage has no reset; valid only rises over written entries,
    // so leaving it unreset keeps it a plain register file.
    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_data[c];
    end
  end
endmodule

// File: tb/tb_extio8x4_axis_rxfifo2.sv
// Self-checking bench: hand-computed vector table for the directed cases,
// then queue-based reference model for concurrent and randomized traffic.
module tb_extio8x4_axis_rxfifo2;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  extio8x4_axis_rxfifo2_if #(.LW(LW)) bus ();

  extio8x4_axis_rxfifo2 #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       v0;
    logic [7:0] d0;
    logic       r0;
    logic       v1;
    logic [7:0] d1;
    logic       r1;
    logic       e_s0r;
    logic       e_m0v;
    logic [7:0] e_m0d;
    logic       e_s1r;
    logic       e_m1v;
    logic [7:0] e_m1d;
    logic [2:0] e_l0;
    logic [2:0] e_l1;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic v0, input logic [7:0] d0, input logic r0,
                       input logic v1, input logic [7:0] d1, input logic r1);
    flush         = fl;
    bus.s0_tvalid = v0;
    bus.s0_tdata8 = d0;
    bus.m0_tready = r0;
    bus.s1_tvalid = v1;
    bus.s1_tdata8 = d1;
    bus.m1_tready = r1;
  endtask

  function automatic vec_t mk(input logic fl, input logic v0, input logic [7:0] d0, input logic r0,
                              input logic v1, input logic [7:0] d1, input logic r1,
                              input logic s0r, input logic m0v, input logic [7:0] m0d,
                              input logic s1r, input logic m1v, input logic [7:0] m1d,
                              input logic [2:0] l0, input logic [2:0] l1);
    vec_t v;
    v.fl = fl; v.v0 = v0; v.d0 = d0; v.r0 = r0; v.v1 = v1; v.d1 = d1; v.r1 = r1;
    v.e_s0r = s0r; v.e_m0v = m0v; v.e_m0d = m0d;
    v.e_s1r = s1r; v.e_m1v = m1v; v.e_m1d = m1d;
    v.e_l0 = l0; v.e_l1 = l1;
    return v;
  endfunction

  // One clock of traffic checked against the queue model of both channels.
  task automatic mcycle(input logic fl, input logic v0, input logic [7:0] d0, input logic r0,
                        input logic v1, input logic [7:0] d1, input logic r1);
    logic er0, ev0, er1, ev1;
    drive(fl, v0, d0, r0, v1, d1, r1);
    #1;
    er0 = (q0.size() != DEPTH) && !fl;
    ev0 = (q0.size() != 0) && !fl;
    er1 = (q1.size() != DEPTH) && !fl;
    ev1 = (q1.size() != 0) && !fl;
    check("model_s0_tready", bus.s0_tready, er0);
    check("model_m0_tvalid", bus.m0_tvalid, ev0);
    check("model_s1_tready", bus.s1_tready, er1);
    check("model_m1_tvalid", bus.m1_tvalid, ev1);
    if (ev0) check("model_m0_tdata8", bus.m0_tdata8, q0[0]);
    if (ev1) check("model_m1_tdata8", bus.m1_tdata8, q1[0]);
    @(posedge clk);
    #1;
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ev0 && r0) void'(q0.pop_front());
      if (er0 && v0) q0.push_back(d0);
      if (ev1 && r1) void'(q1.pop_front());
      if (er1 && v1) q1.push_back(d1);
    end
    check("model_level0", bus.level0, q0.size());
    check("model_level1", bus.level1, q1.size());
  endtask

  initial begin
    // fl v0 d0 r0 v1 d1 r1 | s0r m0v m0d s1r m1v m1d | l0 l1
    vt[0]  = mk(0,1,8'h11,0, 0,8'h00,0, 1,0,8'h00, 1,0,8'h00, 1,0);
    vt[1]  = mk(0,1,8'h22,0, 0,8'h00,0, 1,1,8'h11, 1,0,8'h00, 2,0);
    vt[2]  = mk(0,1,8'h33,0, 0,8'h00,0, 1,1,8'h11, 1,0,8'h00, 3,0);
    vt[3]  = mk(0,1,8'h44,0, 0,8'h00,0, 1,1,8'h11, 1,0,8'h00, 4,0);
    vt[4]  = mk(0,1,8'h55,0, 0,8'h00,0, 0,1,8'h11, 1,0,8'h00, 4,0);
    vt[5]  = mk(0,1,8'h66,1, 0,8'h00,0, 0,1,8'h11, 1,0,8'h00, 3,0);
    vt[6]  = mk(0,1,8'h77,1, 0,8'h00,0, 1,1,8'h22, 1,0,8'h00, 3,0);
    vt[7]  = mk(0,0,8'h00,1, 0,8'h00,0, 1,1,8'h33, 1,0,8'h00, 2,0);
    vt[8]  = mk(0,0,8'h00,1, 0,8'h00,0, 1,1,8'h44, 1,0,8'h00, 1,0);
    vt[9]  = mk(0,0,8'h00,1, 0,8'h00,0, 1,1,8'h77, 1,0,8'h00, 0,0);
    vt[10] = mk(0,0,8'h00,1, 0,8'h00,1, 1,0,8'h00, 1,0,8'h00, 0,0);
    vt[11] = mk(0,1,8'hA1,0, 1,8'hB1,0, 1,0,8'h00, 1,0,8'h00, 1,1);
    vt[12] = mk(0,1,8'hA2,0, 1,8'hB2,0, 1,1,8'hA1, 1,1,8'hB1, 2,2);
    vt[13] = mk(0,1,8'hA3,0, 0,8'h00,0, 1,1,8'hA1, 1,1,8'hB1, 3,2);
    vt[14] = mk(1,1,8'hA4,1, 1,8'hB3,1, 0,0,8'h00, 0,0,8'h00, 0,0);
    vt[15] = mk(0,0,8'h00,0, 0,8'h00,0, 1,0,8'h00, 1,0,8'h00, 0,0);
    vt[16] = mk(0,0,8'h00,0, 1,8'hC1,0, 1,0,8'h00, 1,0,8'h00, 0,1);
    vt[17] = mk(0,0,8'h00,0, 0,8'h00,1, 1,0,8'h00, 1,1,8'hC1, 0,0);

    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    #12;
    check("rst_s0_tready", bus.s0_tready, 1);
    check("rst_s1_tready", bus.s1_tready, 1);
    check("rst_m0_tvalid", bus.m0_tvalid, 0);
    check("rst_m1_tvalid", bus.m1_tvalid, 0);
    check("rst_level0", bus.level0, 0);
    check("rst_level1", bus.level1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: fill/drain, full plus pop, flush, post-flush delivery.
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].fl, vt[i].v0, vt[i].d0, vt[i].r0, vt[i].v1, vt[i].d1, vt[i].r1);
      #1;
      check($sformatf("vec%0d_s0_tready", i), bus.s0_tready, vt[i].e_s0r);
      check($sformatf("vec%0d_m0_tvalid", i), bus.m0_tvalid, vt[i].e_m0v);
      check($sformatf("vec%0d_s1_tready", i), bus.s1_tready, vt[i].e_s1r);
      check($sformatf("vec%0d_m1_tvalid", i), bus.m1_tvalid, vt[i].e_m1v);
      if (vt[i].e_m0v) check($sformatf("vec%0d_m0_tdata8", i), bus.m0_tdata8, vt[i].e_m0d);
      if (vt[i].e_m1v) check($sformatf("vec%0d_m1_tdata8", i), bus.m1_tdata8, vt[i].e_m1d);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_level0", i), bus.level0, vt[i].e_l0);
      check($sformatf("vec%0d_level1", i), bus.level1, vt[i].e_l1);
    end

    // Latency: byte pushed at T is not visible until T+1.
    drive(0, 0, 8'h00, 0, 1, 8'hA5, 1);
    #1;
    check("lat_m1_tvalid_T", bus.m1_tvalid, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
    #1;
    check("lat_m1_tvalid_T1", bus.m1_tvalid, 1);
    check("lat_m1_tdata8_T1", bus.m1_tdata8, 8'hA5);
    check("lat_level1_T1", bus.level1, 1);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
    @(posedge clk);
    #1;
    check("lat_level1_drained", bus.level1, 0);

    // Concurrent streaming at level 2 across several pointer wraps.
    q0.delete();
    q1.delete();
    mcycle(0, 1, 8'($urandom), 0, 0, 8'h00, 0);
    mcycle(0, 1, 8'($urandom), 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      mcycle(0, 1, 8'($urandom), 1, 0, 8'h00, 0);
      check("conc_level0", bus.level0, 2);
    end

    // Async reset with ch1 full, then first byte after release comes out first.
    for (int i = 0; i < 4; i++) mcycle(0, 0, 8'h00, 0, 1, 8'($urandom), 0);
    check("arst_level1_full", bus.level1, 4);
    #3;
    reset = 1'b1;
    #1;
    check("arst_m1_tvalid", bus.m1_tvalid, 0);
    check("arst_level1", bus.level1, 0);
    check("arst_level0", bus.level0, 0);
    check("arst_s1_tready", bus.s1_tready, 1);
    q0.delete();
    q1.delete();
    #10;
    @(negedge clk);
    reset = 1'b0;
    mcycle(0, 0, 8'h00, 0, 1, 8'h5A, 0);
    check("arst_first_byte", bus.m1_tdata8, 8'h5A);
    mcycle(0, 0, 8'h00, 0, 1, 8'h6B, 1);
    mcycle(0, 0, 8'h00, 0, 0, 8'h00, 1);

    // Randomized traffic on both channels with occasional flush.
    for (int i = 0; i < 400; i++) begin
      mcycle(($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
